block_mac_2x2: RTL
==================

// Module: block_mac_2x2
// PURPOSE
//  2x2 block multiplier that sits downstream of the matrix multiply control unit.
//  On a start_mac request it latches the A and B 2x2 sub-blocks and computes C = A*B.
//  It uses a single time-multiplexed pipelined multiplier, presents c_11..c_22 and
//  pulses done_mac. The control unit consumes these results and forwards them to the
//  block accumulator.
// PARAMETERS
//  data_w      32  element width; signed two's complement
//  MUL_STAGES  2   multiplier pipeline register stages; legal range 1..4
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start_mac  in   1       level request from the control unit; may stay high for several cycles
//  a_11..a_22 in   data_w  A sub-block elements
//  b_11..b_22 in   data_w  B sub-block elements
//  c_11..c_22 out  data_w  C sub-block result; held until the next launch
//  done_mac   out  1       one-cycle pulse when c_* is valid
//  busy       out  1       high from launch until done_mac, inclusive
// BEHAVIOUR
//  Reset:
//   - Asynchronous, active-low, effective at any time, including mid-operation.
//   - Reset values: c_*=0, done_mac=0, busy=0, state=IDLE, armed=1, all pipe valid bits and accumulators 0.
//  Launch:
//   - Launch occurs at the edge E0 where state==IDLE, armed==1 and start_mac==1.
//   - At E0 all 8 operands are latched, armed clears, and the block enters ISSUE.
//   - armed sets again on the first edge where start_mac==0.
//   - A start_mac held high therefore yields exactly one computation.
//   - start_mac is ignored while busy, and operand changes after E0 are ignored.
//  States:
//   - IDLE -> ISSUE on launch.
//   - ISSUE: 8 cycles, 3-bit issue counter 0..7, one product issued per cycle in fixed order:
//     a11*b11, a12*b21, a11*b12, a12*b22, a21*b11, a22*b21, a21*b12, a22*b22.
//     Each even/odd pair targets c11, c12, c21, c22 respectively.
//   - ISSUE -> DRAIN after the counter reaches 7.
//   - DRAIN: wait until the last product exits the multiplier pipe and is accumulated.
//   - DONE: one cycle; c_* updated from the accumulators, done_mac=1, busy=1.
//   - DONE -> IDLE unconditionally.
//  Pipeline and accumulation:
//   - Each issued product carries a valid bit and a 2-bit target tag down the pipe.
//   - The first product of each pair loads the accumulator; the second adds to it.
//   - Accumulators need no clear between runs.
//  Latency:
//   - done_mac is high in the cycle after edge E0 + 9 + MUL_STAGES (E0+11 for default).
//   - The next launch can occur at the first edge after DONE, provided armed==1.
//  Arithmetic:
//   - Products use the low data_w bits of the signed product.
//   - Sums wrap modulo 2^data_w; no saturation and no overflow flag.
//  Outputs:
//   - c_* change only on the DONE edge and are stable otherwise, including while busy.
//  Boundary conditions:
//   - start_mac pulse of exactly 1 cycle: launches.
//   - start_mac high during DONE while armed==0: no relaunch.
//   - start_mac low at the DONE edge and high the next cycle: launches.
//   - rst_n low mid-ISSUE: immediate abort, done_mac is never emitted, c_* forced to 0.
// STRUCTURE
//  Shared package (mac_pkg):
//   - state encoding IDLE/ISSUE/DRAIN/DONE
//   - 8-entry issue schedule table: A select, B select, target tag, load/add flag
//   - default MUL_STAGES
//  Sub-module mac_mult_pipe (data_w, MUL_STAGES):
//   - signed multiply, truncated to data_w
//   - pipelined valid and tag sideband
//   - asynchronous active-low reset clears the valid bits
//  Top level: FSM, armed flag, operand latch, issue counter, four accumulators, output registers.
// TESTING
//  1. A=[1 2;3 4], B=[5 6;7 8], start_mac held 3 cycles
//     -> C=[19 22;43 50], done_mac one pulse at E0+11, single launch only.
//  2. A=identity, B=[-3 9;0x7FFFFFFF -1] -> C equals B exactly; sign preserved.
//  3. A=[0x7FFFFFFF 1;0 0], B=[2 0;1 0] -> c_11=0xFFFFFFFF (wrap); c_12=c_21=c_22=0.
//  4. start_mac re-pulsed with new operands mid-ISSUE
//     -> ignored, C from the first operands, busy continuous, no extra done_mac.
//  5. rst_n low at cycle E0+4
//     -> c_*=0, busy=0, no done_mac; a launch after release computes correct C.
//  6. Back-to-back: start_mac drops at the DONE edge and rises the next cycle
//     -> second launch accepted; both results correct; MUL_STAGES swept over 1..4.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the 2x2 block MAC: FSM states, issue schedule and
// default multiplier depth.
package mac_pkg;

  localparam int MUL_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Operand select: 0 = x11, 1 = x12, 2 = x21, 3 = x22. Tag picks c11/c12/c21/c22.
  typedef struct packed {
    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] tag;
    logic       load;
  } sched_t;

  function automatic sched_t sched_lookup(input logic [2:0] idx);
    sched_t s;
    case (idx)
      3'd0:    s = '{a_sel: 2'd0, b_sel: 2'd0, tag: 2'd0, load: 1'b1};
      3'd1:    s = '{a_sel: 2'd1, b_sel: 2'd2, tag: 2'd0, load: 1'b0};
      3'd2:    s = '{a_sel: 2'd0, b_sel: 2'd1, tag: 2'd1, load: 1'b1};
      3'd3:    s = '{a_sel: 2'd1, b_sel: 2'd3, tag: 2'd1, load: 1'b0};
      3'd4:    s = '{a_sel: 2'd2, b_sel: 2'd0, tag: 2'd2, load: 1'b1};
      3'd5:    s = '{a_sel: 2'd3, b_sel: 2'd2, tag: 2'd2, load: 1'b0};
      3'd6:    s = '{a_sel: 2'd2, b_sel: 2'd1, tag: 2'd3, load: 1'b1};
      3'd7:    s = '{a_sel: 2'd3, b_sel: 2'd3, tag: 2'd3, load: 1'b0};
      default: s = '{a_sel: 2'd0, b_sel: 2'd0, tag: 2'd0, load: 1'b1};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Pipelined signed multiplier, result truncated to data_w, with valid/tag/load
// sideband travelling alongside each product.
module mac_mult_pipe #(
  parameter int data_w     = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [1:0]        i_tag,
  input  logic              i_load,
  input  logic [data_w-1:0] i_a,
  input  logic [data_w-1:0] i_b,
  output logic              o_valid,
  output logic [1:0]        o_tag,
  output logic              o_load,
  output logic [data_w-1:0] o_prod,
  output logic              o_any_valid
);

  logic [2*data_w-1:0]   w_a_ext;
  logic [2*data_w-1:0]   w_b_ext;
  logic [2*data_w-1:0]   w_full;
  logic [MUL_STAGES-1:0] r_vld;
  logic [data_w-1:0]     r_prod [MUL_STAGES];
  logic [1:0]            r_tag  [MUL_STAGES];
  logic                  r_load [MUL_STAGES];

  assign w_a_ext = {{data_w{i_a[data_w-1]}}, i_a};
  assign w_b_ext = {{data_w{i_b[data_w-1]}}, i_b};
  assign w_full  = w_a_ext * w_b_ext;

  // Product and sideband shift register; reset drops every in-flight product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        r_prod[i] <= '0;
        r_tag[i]  <= 2'd0;
        r_load[i] <= 1'b0;
      end
    end else begin
      r_vld[0]  <= i_valid;
      r_prod[0] <= w_full[data_w-1:0];
      r_tag[0]  <= i_tag;
      r_load[0] <= i_load;
      for (int i = 1; i < MUL_STAGES; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_prod[i] <= r_prod[i-1];
        r_tag[i]  <= r_tag[i-1];
        r_load[i] <= r_load[i-1];
      end
    end
  end

  assign o_valid     = r_vld[MUL_STAGES-1];
  assign o_tag       = r_tag[MUL_STAGES-1];
  assign o_load      = r_load[MUL_STAGES-1];
  assign o_prod      = r_prod[MUL_STAGES-1];
  assign o_any_valid = |r_vld;

endmodule

// File: rtl/block_mac_2x2.sv
// 2x2 block multiplier C = A*B using one time-multiplexed pipelined multiplier;
// results are held on c_* until the next launch and flagged by a done_mac pulse.
module block_mac_2x2
  import mac_pkg::*;
#(
  parameter int data_w     = 32,
  parameter int MUL_STAGES = MUL_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_mac,
  input  logic [data_w-1:0] a_11,
  input  logic [data_w-1:0] a_12,
  input  logic [data_w-1:0] a_21,
  input  logic [data_w-1:0] a_22,
  input  logic [data_w-1:0] b_11,
  input  logic [data_w-1:0] b_12,
  input  logic [data_w-1:0] b_21,
  input  logic [data_w-1:0] b_22,
  output logic [data_w-1:0] c_11,
  output logic [data_w-1:0] c_12,
  output logic [data_w-1:0] c_21,
  output logic [data_w-1:0] c_22,
  output logic              done_mac,
  output logic              busy
);

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_armed;
  logic [data_w-1:0] r_a   [4];
  logic [data_w-1:0] r_b   [4];
  logic [data_w-1:0] r_acc [4];

  sched_t            w_sch;
  logic              w_launch;
  logic              w_m_valid;
  logic [1:0]        w_m_tag;
  logic              w_m_load;
  logic [data_w-1:0] w_m_prod;
  logic              w_pipe_busy;

  assign w_sch    = sched_lookup(r_cnt);
  assign w_launch = (r_state == ST_IDLE) && r_armed && start_mac;

  mac_mult_pipe #(
    .data_w     (data_w),
    .MUL_STAGES (MUL_STAGES)
  ) u_mult (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (r_state == ST_ISSUE),
    .i_tag       (w_sch.tag),
    .i_load      (w_sch.load),
    .i_a         (r_a[w_sch.a_sel]),
    .i_b         (r_b[w_sch.b_sel]),
    .o_valid     (w_m_valid),
    .o_tag       (w_m_tag),
    .o_load      (w_m_load),
    .o_prod      (w_m_prod),
    .o_any_valid (w_pipe_busy)
  );

  // Re-arm only after start_mac is seen low, so a held request yields one run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
    end else if (!start_mac) begin
      r_armed <= 1'b1;
    end else if (w_launch) begin
      r_armed <= 1'b0;
    end
  end

  // First product of a pair loads its accumulator, so no clear is needed between runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_acc[i] <= '0;
    end else if (w_m_valid) begin
      if (w_m_load) r_acc[w_m_tag] <= w_m_prod;
      else          r_acc[w_m_tag] <= r_acc[w_m_tag] + w_m_prod;
    end
  end

  // Control FSM with operand latch and registered outputs; DRAIN ends once the pipe is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      busy     <= 1'b0;
      done_mac <= 1'b0;
      c_11     <= '0;
      c_12     <= '0;
      c_21     <= '0;
      c_22     <= '0;
      for (int i = 0; i < 4; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      done_mac <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_a[0]  <= a_11;
            r_a[1]  <= a_12;
            r_a[2]  <= a_21;
            r_a[3]  <= a_22;
            r_b[0]  <= b_11;
            r_b[1]  <= b_12;
            r_b[2]  <= b_21;
            r_b[3]  <= b_22;
            r_cnt   <= 3'd0;
            busy    <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!w_pipe_busy) begin
            c_11     <= r_acc[0];
            c_12     <= r_acc[1];
            c_21     <= r_acc[2];
            c_22     <= r_acc[3];
            done_mac <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
